// File: rtl/dsi_packet_parser.sv
// dsi_packet_parser: DSI RX deframer with header ECC check, payload CRC-16, payload streaming and saturating counters.
// Define DSI_RX_ECC_CORRECT_EN to enable single-bit header ECC correction.
module dsi_packet_parser #(
  parameter int g_cnt_width = 16,
  parameter int g_max_wc    = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_sot_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  input  logic                   rx_eot_i,
  input  logic                   cnt_clr_i,
  output logic                   hdr_valid_o,
  output logic [1:0]             hdr_vc_o,
  output logic [5:0]             hdr_dt_o,
  output logic [15:0]            hdr_wc_o,
  output logic                   hdr_long_o,
  output logic [7:0]             pl_data_o,
  output logic                   pl_valid_o,
  output logic                   pl_last_o,
  output logic                   pkt_done_o,
  output logic                   crc_err_o,
  output logic                   ecc_corr_o,
  output logic                   hdr_err_o,
  output logic                   trunc_err_o,
  output logic                   busy_o,
  output logic [g_cnt_width-1:0] pkt_cnt_o,
  output logic [g_cnt_width-1:0] err_cnt_o
);
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, SKIP} state_t;
  localparam logic [23:0] M0 = 24'hF12CB7, M1 = 24'hF2555B, M2 = 24'h749A6D;
  localparam logic [23:0] M3 = 24'hB8E38E, M4 = 24'hDF03F0, M5 = 24'hEFFC00;
  function automatic logic [5:0] ecc_f(input logic [23:0] d);
    return {^(d & M5), ^(d & M4), ^(d & M3), ^(d & M2), ^(d & M1), ^(d & M0)};
  endfunction
  function automatic logic [15:0] crc_f(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, crc_q, crc_d, hdr_wc_q, hdr_wc_d, wc_fix;
  logic [7:0] di_q, di_d, wcl_q, wcl_d, wch_q, wch_d, crcl_q, crcl_d, pl_data_q, pl_data_d;
  logic [5:0] hdr_dt_q, hdr_dt_d, syn;
  logic [1:0] hdr_vc_q, hdr_vc_d;
  logic hdr_valid_q, hdr_valid_d, hdr_long_q, hdr_long_d, pl_valid_q, pl_valid_d;
  logic pl_last_q, pl_last_d, pkt_done_q, pkt_done_d, crc_err_q, crc_err_d;
  logic ecc_corr_q, ecc_corr_d, hdr_err_q, hdr_err_d, trunc_err_q, trunc_err_d;
  logic [g_cnt_width-1:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [23:0] hdr_raw, hdr_fix;
  logic sot, eot, bv, partial, is_long, wc_bad, ecc_bad, ecc_fix;
  always_comb begin
    hdr_raw = {wch_q, wcl_q, di_q};
    syn = rx_data_i[5:0] ^ ecc_f(hdr_raw);
    hdr_fix = hdr_raw;
    ecc_fix = 1'b0;
`ifdef DSI_RX_ECC_CORRECT_EN
    for (int i = 0; i < 24; i++)
      if (syn == ecc_f(24'd1 << i)) begin
        hdr_fix[i] = ~hdr_raw[i];
        ecc_fix = 1'b1;
      end
    if ($onehot(syn)) ecc_fix = 1'b1;
`endif
    ecc_bad = (syn != 6'd0) && !ecc_fix;
    wc_fix = hdr_fix[23:8];
    is_long = hdr_fix[3] && (hdr_fix[2:0] != 3'd0);
    wc_bad = is_long && (32'(wc_fix) > g_max_wc);
  end
  // sot has priority over eot; a byte coinciding with either is dropped
  always_comb begin
    sot = rx_sot_i;
    eot = rx_eot_i && !rx_sot_i;
    bv = rx_valid_i && !rx_eot_i && !rx_sot_i;
    partial = (state_q == HDR && cnt_q != 16'd0) || state_q == PAYLOAD || state_q == CRC;
    state_d = state_q;
    cnt_d = cnt_q;
    crc_d = crc_q;
    di_d = di_q;
    wcl_d = wcl_q;
    wch_d = wch_q;
    crcl_d = crcl_q;
    hdr_vc_d = hdr_vc_q;
    hdr_dt_d = hdr_dt_q;
    hdr_wc_d = hdr_wc_q;
    hdr_long_d = hdr_long_q;
    pl_data_d = pl_data_q;
    hdr_valid_d = 1'b0;
    pl_valid_d = 1'b0;
    pl_last_d = 1'b0;
    pkt_done_d = 1'b0;
    crc_err_d = 1'b0;
    ecc_corr_d = 1'b0;
    hdr_err_d = 1'b0;
    trunc_err_d = 1'b0;
    if (sot) begin
      state_d = HDR;
      cnt_d = 16'd0;
      trunc_err_d = partial;
    end else if (eot) begin
      state_d = IDLE;
      trunc_err_d = partial;
    end else if (bv) begin
      case (state_q)
        HDR: begin
          cnt_d = cnt_q + 16'd1;
          di_d = (cnt_q == 16'd0) ? rx_data_i : di_q;
          wcl_d = (cnt_q == 16'd1) ? rx_data_i : wcl_q;
          wch_d = (cnt_q == 16'd2) ? rx_data_i : wch_q;
          if (cnt_q == 16'd3) begin
            cnt_d = 16'd0;
            if (ecc_bad || wc_bad) begin
              state_d = SKIP;
              hdr_err_d = 1'b1;
            end else begin
              hdr_valid_d = 1'b1;
              ecc_corr_d = ecc_fix;
              hdr_vc_d = hdr_fix[7:6];
              hdr_dt_d = hdr_fix[5:0];
              hdr_wc_d = wc_fix;
              hdr_long_d = is_long;
              crc_d = 16'hFFFF;
              pkt_done_d = !is_long;
              state_d = !is_long ? HDR : (wc_fix == 16'd0) ? CRC : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d = rx_data_i;
          pl_last_d = (cnt_q == hdr_wc_q - 16'd1);
          crc_d = crc_f(crc_q, rx_data_i);
          cnt_d = pl_last_d ? 16'd0 : cnt_q + 16'd1;
          state_d = pl_last_d ? CRC : PAYLOAD;
        end
        CRC: begin
          crcl_d = rx_data_i;
          cnt_d = (cnt_q == 16'd0) ? 16'd1 : 16'd0;
          pkt_done_d = (cnt_q != 16'd0);
          crc_err_d = (cnt_q != 16'd0) && ({rx_data_i, crcl_q} != crc_q);
          state_d = (cnt_q != 16'd0) ? HDR : CRC;
        end
        default: ;
      endcase
    end
    pkt_cnt_d = cnt_clr_i ? '0 : (pkt_done_d && !crc_err_d && !(&pkt_cnt_q)) ? pkt_cnt_q + g_cnt_width'(1) : pkt_cnt_q;
    err_cnt_d = cnt_clr_i ? '0 : ((crc_err_d || hdr_err_d || trunc_err_d) && !(&err_cnt_q)) ? err_cnt_q + g_cnt_width'(1) : err_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      crc_q <= '0;
      di_q <= '0;
      wcl_q <= '0;
      wch_q <= '0;
      crcl_q <= '0;
      hdr_vc_q <= '0;
      hdr_dt_q <= '0;
      hdr_wc_q <= '0;
      hdr_long_q <= 1'b0;
      pl_data_q <= '0;
      hdr_valid_q <= 1'b0;
      pl_valid_q <= 1'b0;
      pl_last_q <= 1'b0;
      pkt_done_q <= 1'b0;
      crc_err_q <= 1'b0;
      ecc_corr_q <= 1'b0;
      hdr_err_q <= 1'b0;
      trunc_err_q <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      crc_q <= crc_d;
      di_q <= di_d;
      wcl_q <= wcl_d;
      wch_q <= wch_d;
      crcl_q <= crcl_d;
      hdr_vc_q <= hdr_vc_d;
      hdr_dt_q <= hdr_dt_d;
      hdr_wc_q <= hdr_wc_d;
      hdr_long_q <= hdr_long_d;
      pl_data_q <= pl_data_d;
      hdr_valid_q <= hdr_valid_d;
      pl_valid_q <= pl_valid_d;
      pl_last_q <= pl_last_d;
      pkt_done_q <= pkt_done_d;
      crc_err_q <= crc_err_d;
      ecc_corr_q <= ecc_corr_d;
      hdr_err_q <= hdr_err_d;
      trunc_err_q <= trunc_err_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign hdr_valid_o = hdr_valid_q;
  assign hdr_vc_o = hdr_vc_q;
  assign hdr_dt_o = hdr_dt_q;
  assign hdr_wc_o = hdr_wc_q;
  assign hdr_long_o = hdr_long_q;
  assign pl_data_o = pl_data_q;
  assign pl_valid_o = pl_valid_q;
  assign pl_last_o = pl_last_q;
  assign pkt_done_o = pkt_done_q;
  assign crc_err_o = crc_err_q;
  assign ecc_corr_o = ecc_corr_q;
  assign hdr_err_o = hdr_err_q;
  assign trunc_err_o = trunc_err_q;
  assign busy_o = (state_q != IDLE);
  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
endmodule
